// File: rtl/tetris_cmd_queue.sv
// Player command queue and gravity timer between the tetris_v2 register slave
// and the game engine; issues one move request at a time over valid/ready.
module tetris_cmd_queue #(
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 32
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         cmd_wr,
  input  logic [31:0]                  cmd_data,
  input  logic                         enable,
  input  logic [3:0]                   level,
  input  logic                         sts_clr,
  output logic                         mv_valid,
  output logic [2:0]                   mv_op,
  input  logic                         mv_ready,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic                         ovf,
  output logic                         ill,
  output logic                         grav_miss
);

  localparam int AW = $clog2(DEPTH);
  localparam int QW = $clog2(DEPTH+1);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1'b1);
  localparam logic [QW-1:0]    Q_ONE   = QW'(1'b1);
  localparam logic [QW-1:0]    Q_FULL  = QW'(DEPTH);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1'b1);

  // Gravity reload value: (TICK_DIV >> min(level,7)) - 1, period clamped to at least 1
  function automatic logic [CNT_W-1:0] grav_reload(input logic [3:0] lvl);
    logic [2:0]       sh;
    logic [CNT_W-1:0] p;
    if (lvl > 4'd7) begin
      sh = 3'd7;
    end else begin
      sh = lvl[2:0];
    end
    p = CNT_W'(TICK_DIV) >> sh;
    if (p == '0) begin
      p = C_ONE;
    end else begin
      p = p;
    end
    return p - C_ONE;
  endfunction

  logic [2:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [QW-1:0]    r_count;
  logic             r_mv_valid;
  logic [2:0]       r_mv_op;
  logic             r_grav_pend;
  logic [CNT_W-1:0] r_gcnt;
  logic             r_ginit;
  logic             r_ovf, r_ill, r_grav_miss;

  logic [2:0]       w_op;
  logic             w_push_req, w_flush, w_ill_set;
  logic             w_full, w_push, w_pop;
  logic             w_slot_free, w_grav_load;
  logic [CNT_W-1:0] w_reload, w_gcnt;
  logic             w_tick, w_ovf_set, w_miss_set;
  logic             w_unused;

  assign w_op     = cmd_data[2:0];
  assign w_unused = ^cmd_data[31:3];

  // Opcode decode of each command-register write
  always_comb begin
    w_push_req = 1'b0;
    w_flush    = 1'b0;
    w_ill_set  = 1'b0;
    if (cmd_wr) begin
      case (w_op)
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5: w_push_req = 1'b1;
        3'd6:                         w_flush    = 1'b1;
        3'd7:                         w_ill_set  = 1'b1;
        default:                      w_push_req = 1'b0;
      endcase
    end else begin
      w_push_req = 1'b0;
    end
  end

  assign w_full      = (r_count == Q_FULL);
  assign w_slot_free = !r_mv_valid || mv_ready;
  assign w_grav_load = w_slot_free && r_grav_pend;
  assign w_pop       = w_slot_free && !r_grav_pend && (r_count != '0);
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_ovf_set   = w_push_req && w_full && !w_pop;

  // r_ginit stands in for "counter holds period-1" straight out of reset
  assign w_reload   = grav_reload(level);
  assign w_gcnt     = r_ginit ? w_reload : r_gcnt;
  assign w_tick     = enable && (w_gcnt == '0);
  assign w_miss_set = w_tick && r_grav_pend && !w_grav_load;

  // FIFO storage; entries need no reset since occupancy gates every read
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_op;
    end
  end

  // FIFO pointers and occupancy; FLUSH snaps the read pointer onto the write pointer
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_rptr  <= r_wptr;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + Q_ONE;
        2'b01:   r_count <= r_count - Q_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Gravity down-counter and pending request; a fresh tick outranks its own consumption
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_gcnt      <= '0;
      r_ginit     <= 1'b1;
      r_grav_pend <= 1'b0;
    end else begin
      r_ginit <= 1'b0;
      if (!enable || (w_gcnt == '0)) begin
        r_gcnt <= w_reload;
      end else begin
        r_gcnt <= w_gcnt - C_ONE;
      end
      if (w_tick) begin
        r_grav_pend <= 1'b1;
      end else if (w_grav_load) begin
        r_grav_pend <= 1'b0;
      end else begin
        r_grav_pend <= r_grav_pend;
      end
    end
  end

  // Output slot: gravity first, then FIFO head; held until accepted
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_mv_valid <= 1'b0;
      r_mv_op    <= 3'd0;
    end else if (w_grav_load) begin
      r_mv_valid <= 1'b1;
      r_mv_op    <= 3'd4;
    end else if (w_pop) begin
      r_mv_valid <= 1'b1;
      r_mv_op    <= r_mem[r_rptr];
    end else if (w_slot_free) begin
      r_mv_valid <= 1'b0;
      r_mv_op    <= 3'd0;
    end else begin
      r_mv_valid <= r_mv_valid;
      r_mv_op    <= r_mv_op;
    end
  end

  // Sticky status flags; a set event beats a simultaneous clear
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
      r_grav_miss <= 1'b0;
    end else begin
      r_ovf       <= w_ovf_set  | (r_ovf       & ~sts_clr);
      r_ill       <= w_ill_set  | (r_ill       & ~sts_clr);
      r_grav_miss <= w_miss_set | (r_grav_miss & ~sts_clr);
    end
  end

  assign mv_valid  = r_mv_valid;
  assign mv_op     = r_mv_op;
  assign q_count   = r_count;
  assign ovf       = r_ovf;
  assign ill       = r_ill;
  assign grav_miss = r_grav_miss;

endmodule

// File: tb/tb_tetris_cmd_queue.sv
// Directed bench for tetris_cmd_queue: latency, FIFO boundaries, gravity timing,
// flush/illegal opcodes and asynchronous reset, with hand-computed expectations.
module tb_tetris_cmd_queue;

  logic        ACLK = 1'b0;
  logic        ARESET, cmd_wr, enable, sts_clr, mv_ready;
  logic [31:0] cmd_data;
  logic [3:0]  level;
  logic        mv_valid, ovf, ill, grav_miss;
  logic [2:0]  mv_op;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_errors = 0;

  tetris_cmd_queue #(.DEPTH(4), .TICK_DIV(16), .CNT_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cmd_wr(cmd_wr), .cmd_data(cmd_data),
    .enable(enable), .level(level), .sts_clr(sts_clr),
    .mv_valid(mv_valid), .mv_op(mv_op), .mv_ready(mv_ready),
    .q_count(q_count), .ovf(ovf), .ill(ill), .grav_miss(grav_miss)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic slot(input string tag, input logic v, input logic [2:0] op, input logic [2:0] q);
    check({tag, "_valid"}, 32'(mv_valid), 32'(v));
    if (v) check({tag, "_op"}, 32'(mv_op), 32'(op));
    check({tag, "_qcount"}, 32'(q_count), 32'(q));
  endtask

  initial begin
    logic [2:0] ops2 [6];
    logic [2:0] q2   [6];
    logic [2:0] out2 [4];
    logic [2:0] ops5 [4];
    logic [2:0] q5   [4];
    ops2 = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd2, 3'd1};
    q2   = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    out2 = '{3'd3, 3'd5, 3'd2, 3'd4};
    ops5 = '{3'd3, 3'd1, 3'd2, 3'd5};
    q5   = '{3'd1, 3'd1, 3'd2, 3'd3};

    ARESET = 1'b1; cmd_wr = 1'b0; cmd_data = 32'd0; enable = 1'b0;
    level = 4'd0; sts_clr = 1'b0; mv_ready = 1'b0;
    repeat (2) step();
    check("rst_valid", 32'(mv_valid), 32'd0);
    check("rst_op", 32'(mv_op), 32'd0);
    check("rst_qcount", 32'(q_count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ill", 32'(ill), 32'd0);
    check("rst_miss", 32'(grav_miss), 32'd0);
    ARESET = 1'b0;

    // Single command: two-cycle latency, one-cycle-wide request; upper data bits ignored
    mv_ready = 1'b1;
    cmd_wr = 1'b1; cmd_data = 32'hABCD_0001;
    step();
    cmd_wr = 1'b0;
    slot("t1_e1", 1'b0, 3'd0, 3'd1);
    step();
    slot("t1_e2", 1'b1, 3'd1, 3'd0);
    step();
    slot("t1_e3", 1'b0, 3'd0, 3'd0);

    // Fill slot plus FIFO, drop one, then push while popping a full FIFO
    mv_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_wr = 1'b1; cmd_data = 32'(ops2[i]);
      step();
      check($sformatf("t2_q%0d", i), 32'(q_count), 32'(q2[i]));
      check($sformatf("t2_ovf%0d", i), 32'(ovf), (i == 5) ? 32'd1 : 32'd0);
    end
    cmd_wr = 1'b0;
    slot("t2_head", 1'b1, 3'd1, 3'd4);
    mv_ready = 1'b1; cmd_wr = 1'b1; cmd_data = 32'd4;
    step();
    cmd_wr = 1'b0;
    slot("t2_fullpp", 1'b1, 3'd2, 3'd4);
    for (int i = 0; i < 4; i++) begin
      step();
      slot($sformatf("t2_out%0d", i), 1'b1, out2[i], 3'(3 - i));
    end
    step();
    slot("t2_drain", 1'b0, 3'd0, 3'd0);
    check("t2_ovf_held", 32'(ovf), 32'd1);
    sts_clr = 1'b1;
    step();
    sts_clr = 1'b0;
    check("t2_ovf_clr", 32'(ovf), 32'd0);

    // Gravity: period 4 at level 2, then 16 after switching to level 0
    level = 4'd2;
    step();
    enable = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      check($sformatf("t3_v%0d", k), 32'(mv_valid), (k == 5 || k == 9 || k == 13) ? 32'd1 : 32'd0);
      if (k == 5 || k == 9 || k == 13) check($sformatf("t3_op%0d", k), 32'(mv_op), 32'd4);
    end
    level = 4'd0;
    for (int k = 14; k <= 34; k++) begin
      step();
      check($sformatf("t3_v%0d", k), 32'(mv_valid), (k == 17 || k == 33) ? 32'd1 : 32'd0);
    end
    check("t3_miss", 32'(grav_miss), 32'd0);
    enable = 1'b0;
    level = 4'd2;
    step();

    // Gravity beats queued command; second tick while held sets grav_miss
    mv_ready = 1'b0;
    enable = 1'b1;
    repeat (3) step();
    cmd_wr = 1'b1; cmd_data = 32'd2;
    step();
    cmd_wr = 1'b0;
    slot("t4_e4", 1'b0, 3'd0, 3'd1);
    step();
    slot("t4_e5", 1'b1, 3'd4, 3'd1);
    repeat (6) step();
    check("t4_miss_e11", 32'(grav_miss), 32'd0);
    step();
    check("t4_miss_e12", 32'(grav_miss), 32'd1);
    slot("t4_e12", 1'b1, 3'd4, 3'd1);
    enable = 1'b0; mv_ready = 1'b1;
    step();
    slot("t4_e13", 1'b1, 3'd4, 3'd1);
    step();
    slot("t4_e14", 1'b1, 3'd2, 3'd0);
    step();
    slot("t4_e15", 1'b0, 3'd0, 3'd0);
    sts_clr = 1'b1;
    step();
    sts_clr = 1'b0;
    check("t4_miss_clr", 32'(grav_miss), 32'd0);

    // FLUSH empties the queue, opcode 7 flags ill, slot content survives
    mv_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_wr = 1'b1; cmd_data = 32'(ops5[i]);
      step();
      check($sformatf("t5_q%0d", i), 32'(q_count), 32'(q5[i]));
    end
    cmd_data = 32'd6;
    step();
    slot("t5_flush", 1'b1, 3'd3, 3'd0);
    cmd_data = 32'd7;
    step();
    check("t5_ill", 32'(ill), 32'd1);
    sts_clr = 1'b1;
    step();
    check("t5_ill_setwins", 32'(ill), 32'd1);
    cmd_wr = 1'b0;
    step();
    sts_clr = 1'b0;
    check("t5_ill_clr", 32'(ill), 32'd0);
    slot("t5_held", 1'b1, 3'd3, 3'd0);
    mv_ready = 1'b1;
    step();
    slot("t5_issued", 1'b0, 3'd0, 3'd0);

    // Asynchronous reset in the middle of a held handshake
    mv_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cmd_wr = 1'b1; cmd_data = 32'(i);
      step();
    end
    cmd_wr = 1'b0;
    slot("t6_pre", 1'b1, 3'd1, 3'd3);
    #2;
    ARESET = 1'b1;
    #1;
    check("t6_valid", 32'(mv_valid), 32'd0);
    check("t6_op", 32'(mv_op), 32'd0);
    check("t6_qcount", 32'(q_count), 32'd0);
    check("t6_ill", 32'(ill), 32'd0);
    step();
    ARESET = 1'b0;
    mv_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      slot($sformatf("t6_post%0d", i), 1'b0, 3'd0, 3'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
